// File: rtl/mem_access.sv
// mem_access: data-memory stage of the five-stage MIPS pipeline.
// Issues one request/ready transaction per load or store, aligns and
// extends load data, stalls upstream while the access is outstanding and
// registers the write-back bundle.
// Ports:
//   clk, rst (sync, active-low), flush        - clock, reset, instruction kill
//   pc, exe_data, busB                        - PC, effective address/ALU result, store data
//   memReadEn, memWriteEn, load_sign          - lane masks and load extension mode
//   mem_to_reg, reg_wen, reg_num              - write-back control
//   stall_out                                 - combinational upstream hold
//   dmem_req/wr/addr/be/wdata, dmem_ready/rdata - data-memory port
//   wb_data, wb_reg_wen, wb_reg_num, wb_pc    - registered write-back bundle
//   addr_error_out, bad_vaddr_out             - AdEL/AdES report
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] exe_data,
  input  logic [31:0] busB,
  input  logic [3:0]  memReadEn,
  input  logic [3:0]  memWriteEn,
  input  logic        load_sign,
  input  logic        mem_to_reg,
  input  logic        reg_wen,
  input  logic [4:0]  reg_num,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic        wb_reg_wen,
  output logic [4:0]  wb_reg_num,
  output logic [31:0] wb_pc,
  output logic        addr_error_out,
  output logic [31:0] bad_vaddr_out
);

  localparam int unsigned DW = 32;
  localparam int unsigned NB = 4;
  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [NB-1:0]   be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      off_q, off_d;
  logic            sign_q, sign_d;
  logic [DW-1:0]   lbuf_q, lbuf_d;
  logic            killed_q, killed_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic            wb_wen_q, wb_wen_d;
  logic [RW-1:0]   wb_num_q, wb_num_d;
  logic [DW-1:0]   wb_pc_q, wb_pc_d;
  logic            aerr_q, aerr_d;
  logic [DW-1:0]   badv_q, badv_d;

  logic            misaligned;
  logic            pending;
  logic [NB-1:0]   lane_mask;
  logic [DW-1:0]   store_data;
  logic [DW-1:0]   rd_shifted;
  logic [DW-1:0]   load_ext;

  // Alignment / legality of the lane mask against the low address bits
  always_comb begin
    misaligned = 1'b0;
    lane_mask  = memReadEn | memWriteEn;
    if ((memReadEn != '0) && (memWriteEn != '0)) begin
      misaligned = 1'b1;
    end else begin
      case (lane_mask)
        4'b0000: misaligned = 1'b0;
        4'b0001, 4'b0010, 4'b0100, 4'b1000:
          misaligned = (lane_mask != (4'b0001 << exe_data[1:0]));
        4'b0011, 4'b1100:
          misaligned = exe_data[0] | (lane_mask != (exe_data[1] ? 4'b1100 : 4'b0011));
        4'b1111: misaligned = (exe_data[1:0] != 2'b00);
        default: misaligned = 1'b1;
      endcase
    end
  end

  assign pending = (lane_mask != '0) & ~flush & ~misaligned;

  // Replicate the store operand across every lane it may land in
  always_comb begin
    case (memWriteEn)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: store_data = {4{busB[7:0]}};
      4'b0011, 4'b1100:                   store_data = {2{busB[15:0]}};
      default:                            store_data = busB;
    endcase
  end

  // Load alignment uses the offset and size captured at issue time
  assign rd_shifted = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (be_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        load_ext = sign_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                          : {24'h000000, rd_shifted[7:0]};
      4'b0011, 4'b1100:
        load_ext = sign_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                          : {16'h0000, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      sign_q    <= 1'b0;
      lbuf_q    <= '0;
      killed_q  <= 1'b0;
      wb_data_q <= '0;
      wb_wen_q  <= 1'b0;
      wb_num_q  <= '0;
      wb_pc_q   <= '0;
      aerr_q    <= 1'b0;
      badv_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      off_q     <= off_d;
      sign_q    <= sign_d;
      lbuf_q    <= lbuf_d;
      killed_q  <= killed_d;
      wb_data_q <= wb_data_d;
      wb_wen_q  <= wb_wen_d;
      wb_num_q  <= wb_num_d;
      wb_pc_q   <= wb_pc_d;
      aerr_q    <= aerr_d;
      badv_q    <= badv_d;
    end
  end

  // Next-state, bus and write-back logic
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    off_d     = off_q;
    sign_d    = sign_q;
    lbuf_d    = lbuf_q;
    killed_d  = killed_q;
    wb_data_d = wb_data_q;
    wb_wen_d  = wb_wen_q;
    wb_num_d  = wb_num_q;
    wb_pc_d   = wb_pc_q;
    aerr_d    = 1'b0;
    badv_d    = badv_q;
    stall_out = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending) begin
          stall_out = 1'b1;
          req_d     = 1'b1;
          wr_d      = (memWriteEn != '0);
          addr_d    = {exe_data[31:2], 2'b00};
          be_d      = (memWriteEn != '0) ? memWriteEn : memReadEn;
          wdata_d   = store_data;
          off_d     = exe_data[1:0];
          sign_d    = load_sign;
          wb_wen_d  = 1'b0;
          state_d   = S_BUSY;
        end else begin
          wb_data_d = exe_data;
          wb_wen_d  = reg_wen & ~flush & ~misaligned;
          wb_num_d  = reg_num;
          wb_pc_d   = pc;
          // A flushed instruction raises no address exception
          if (misaligned && !flush) begin
            aerr_d = 1'b1;
            badv_d = exe_data;
          end
        end
      end
      S_BUSY: begin
        stall_out = 1'b1;
        wb_wen_d  = 1'b0;
        // The bus cycle cannot be aborted; remember the kill for DONE
        if (flush) killed_d = 1'b1;
        if (dmem_ready) begin
          req_d   = 1'b0;
          lbuf_d  = load_ext;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wb_data_d = mem_to_reg ? lbuf_q : exe_data;
        wb_wen_d  = reg_wen & ~killed_q & ~flush;
        wb_num_d  = reg_num;
        wb_pc_d   = pc;
        killed_d  = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dmem_req       = req_q;
  assign dmem_wr        = wr_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign wb_data        = wb_data_q;
  assign wb_reg_wen     = wb_wen_q;
  assign wb_reg_num     = wb_num_q;
  assign wb_pc          = wb_pc_q;
  assign addr_error_out = aerr_q;
  assign bad_vaddr_out  = badv_q;

endmodule
